// File: rtl/demux_reg4_pkg.sv
// -----------------------------------------------------------------------------
// demux_reg4_pkg
// Shared definitions for the demux_reg4 write-side router:
//   - state_t        : pending-buffer FSM states (ST_EMPTY / ST_FULL)
//   - S0..S3         : destination select codes, identical to the codes used
//                      by the CPU's 4-to-1 operand selector (A..D)
//   - DEF_WIDTH      : default data width of the routed word
// -----------------------------------------------------------------------------
package demux_reg4_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] S0 = 2'b00;  // destination A
    localparam logic [1:0] S1 = 2'b01;  // destination B
    localparam logic [1:0] S2 = 2'b10;  // destination C
    localparam logic [1:0] S3 = 2'b11;  // destination D

    localparam int DEF_WIDTH = 8;

endpackage : demux_reg4_pkg

// File: rtl/demux_reg4_dec2to4.sv
// -----------------------------------------------------------------------------
// demux_reg4_dec2to4
// 2-bit to one-hot 4-bit decoder with enable. Output is all zeros when the
// enable is low.
// Ports:
//   i_sel    [1:0] : destination code (S0..S3)
//   i_en           : decoder enable
//   o_onehot [3:0] : bit i set when i_en and i_sel selects destination i
// -----------------------------------------------------------------------------
module dec2to4
    import demux_reg4_pkg::*;
(
    input  logic [1:0] i_sel,
    input  logic       i_en,
    output logic [3:0] o_onehot
);

    always_comb begin
        o_onehot = 4'b0000;
        if (i_en) begin
            unique case (i_sel)
                S0: o_onehot = 4'b0001;
                S1: o_onehot = 4'b0010;
                S2: o_onehot = 4'b0100;
                S3: o_onehot = 4'b1000;
                default: o_onehot = 4'b0000;
            endcase
        end
    end

endmodule : dec2to4

// File: rtl/demux_reg4.sv
// -----------------------------------------------------------------------------
// demux_reg4
// Write-side counterpart of the 4-to-1 operand selector. A data word and a
// 2-bit destination are accepted over a valid/ready handshake into a one-entry
// pending buffer, then committed into one of four holding registers (OutA..D)
// once the destination's Lock bit is low.
//
// Parameters:
//   WIDTH     : data width of InData and each holding register
//   RESET_VAL : value of OutA..OutD after reset (and after Clear)
// Ports:
//   Clk                  : rising-edge clock
//   Rst_n                : asynchronous active-low reset
//   InData  [WIDTH-1:0]  : write data
//   Sel     [1:0]        : destination 00=A 01=B 10=C 11=D
//   InValid              : write request present
//   InReady              : request can be accepted this cycle
//   Lock    [3:0]        : bit i high blocks writes to destination i
//   OutA..OutD           : holding registers
//   UpdA..UpdD           : one-cycle strobe, high when the new value is visible
//   Busy                 : pending buffer occupied
//   Clear                : (only with DEMUX_REG4_CLEAR_EN) synchronous
//                          active-high clear of registers and pending entry
//
// Configuration macro: DEMUX_REG4_CLEAR_EN adds the Clear input.
// -----------------------------------------------------------------------------
module demux_reg4
    import demux_reg4_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] InData,
    input  logic [1:0]       Sel,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Lock,
`ifdef DEMUX_REG4_CLEAR_EN
    input  logic             Clear,
`endif
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [WIDTH-1:0] OutC,
    output logic [WIDTH-1:0] OutD,
    output logic             UpdA,
    output logic             UpdB,
    output logic             UpdC,
    output logic             UpdD,
    output logic             Busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pend_data;
    logic [1:0]       r_pend_sel;
    logic [WIDTH-1:0] r_out [4];
    logic [3:0]       r_upd;

    logic             w_clear;
    logic             w_commit;
    logic             w_accept;
    logic [3:0]       w_we;

`ifdef DEMUX_REG4_CLEAR_EN
    assign w_clear = Clear;
`else
    assign w_clear = 1'b0;
`endif

    // Only the pending entry's own destination lock can stall it. Clear
    // suppresses the commit so a dropped entry never produces a strobe.
    assign w_commit = (r_state == ST_FULL) && !Lock[r_pend_sel] && !w_clear;
    assign InReady  = ((r_state == ST_EMPTY) || w_commit) && !w_clear;
    assign w_accept = InValid && InReady;
    assign Busy     = (r_state == ST_FULL);

    dec2to4 u_dec (
        .i_sel    (r_pend_sel),
        .i_en     (w_commit),
        .o_onehot (w_we)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_commit && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
        if (w_clear) w_state_nxt = ST_EMPTY;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending payload needs no reset: it is only consumed while ST_FULL.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_pend_data <= InData;
            r_pend_sel  <= Sel;
        end
    end

    // Strobes are the registered write enables, so they rise together with
    // the new register value and stay high on back-to-back same-target writes.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_upd <= 4'b0000;
            for (int i = 0; i < 4; i++) r_out[i] <= RESET_VAL;
        end else if (w_clear) begin
            r_upd <= 4'b0000;
            for (int i = 0; i < 4; i++) r_out[i] <= RESET_VAL;
        end else begin
            r_upd <= w_we;
            for (int i = 0; i < 4; i++) begin
                if (w_we[i]) r_out[i] <= r_pend_data;
            end
        end
    end

    assign OutA = r_out[0];
    assign OutB = r_out[1];
    assign OutC = r_out[2];
    assign OutD = r_out[3];
    assign UpdA = r_upd[0];
    assign UpdB = r_upd[1];
    assign UpdC = r_upd[2];
    assign UpdD = r_upd[3];

endmodule : demux_reg4

// File: tb/tb_demux_reg4.sv
// -----------------------------------------------------------------------------
// tb_demux_reg4
// Directed self-checking bench for demux_reg4 (8-bit, RESET_VAL = 0).
// -----------------------------------------------------------------------------
module tb_demux_reg4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] lock;
    logic [7:0] out_a, out_b, out_c, out_d;
    logic       upd_a, upd_b, upd_c, upd_d;
    logic       busy;
`ifdef DEMUX_REG4_CLEAR_EN
    logic       clear;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0] upd;
    logic [7:0] outs [4];
    assign upd     = {upd_d, upd_c, upd_b, upd_a};
    assign outs[0] = out_a;
    assign outs[1] = out_b;
    assign outs[2] = out_c;
    assign outs[3] = out_d;

    demux_reg4 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .InData  (in_data),
        .Sel     (sel),
        .InValid (in_valid),
        .InReady (in_ready),
        .Lock    (lock),
`ifdef DEMUX_REG4_CLEAR_EN
        .Clear   (clear),
`endif
        .OutA    (out_a),
        .OutB    (out_b),
        .OutC    (out_c),
        .OutD    (out_d),
        .UpdA    (upd_a),
        .UpdB    (upd_b),
        .UpdC    (upd_c),
        .UpdD    (upd_d),
        .Busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        chk({tag, "_A"}, {24'h0, out_a}, {24'h0, a});
        chk({tag, "_B"}, {24'h0, out_b}, {24'h0, b});
        chk({tag, "_C"}, {24'h0, out_c}, {24'h0, c});
        chk({tag, "_D"}, {24'h0, out_d}, {24'h0, d});
    endtask

    initial begin
        logic [7:0] stream_data [4];
        stream_data[0] = 8'h11;
        stream_data[1] = 8'h22;
        stream_data[2] = 8'h33;
        stream_data[3] = 8'h44;

        rst_n    = 1'b0;
        in_data  = 8'h00;
        sel      = 2'b00;
        in_valid = 1'b0;
        lock     = 4'b0000;
`ifdef DEMUX_REG4_CLEAR_EN
        clear    = 1'b0;
`endif

        // Reset then idle
        tick();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_outs("idle_out", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("idle_upd", {28'h0, upd}, 32'h0);
        chk("idle_ready", {31'h0, in_ready}, 32'h1);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // Single write C=5A
        in_data = 8'h5A; sel = 2'b10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("single_busy", {31'h0, busy}, 32'h1);
        chk("single_c_early", {24'h0, out_c}, 32'h00);
        tick();
        chk_outs("single_out", 8'h00, 8'h00, 8'h5A, 8'h00);
        chk("single_upd", {28'h0, upd}, 32'h4);
        chk("single_busy2", {31'h0, busy}, 32'h0);
        tick();
        chk("single_upd_off", {28'h0, upd}, 32'h0);

        // Stream A..D on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            in_data = stream_data[i]; sel = 2'(i); in_valid = 1'b1;
            #1;
            chk("stream_ready", {31'h0, in_ready}, 32'h1);
            tick();
            if (i > 0) begin
                chk("stream_out", {24'h0, outs[i-1]}, {24'h0, stream_data[i-1]});
                chk("stream_upd", {28'h0, upd}, 32'(1 << (i - 1)));
            end
        end
        in_valid = 1'b0;
        tick();
        chk_outs("stream_final", 8'h11, 8'h22, 8'h33, 8'h44);
        chk("stream_upd_d", {28'h0, upd}, 32'h8);
        tick();

        // Lock stall on B, D waiting behind it
        lock = 4'b0010;
        in_data = 8'h77; sel = 2'b01; in_valid = 1'b1;
        tick();
        in_data = 8'h88; sel = 2'b11;
        #1;
        chk("stall_ready", {31'h0, in_ready}, 32'h0);
        chk("stall_busy", {31'h0, busy}, 32'h1);
        tick();
        tick();
        chk_outs("stall_held", 8'h11, 8'h22, 8'h33, 8'h44);
        chk("stall_upd", {28'h0, upd}, 32'h0);
        chk("stall_ready2", {31'h0, in_ready}, 32'h0);
        lock = 4'b0000;
        #1;
        chk("unlock_ready", {31'h0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("unlock_b", {24'h0, out_b}, 32'h77);
        chk("unlock_upd_b", {28'h0, upd}, 32'h2);
        chk("unlock_busy", {31'h0, busy}, 32'h1);
        chk("unlock_d_early", {24'h0, out_d}, 32'h44);
        tick();
        chk_outs("unlock_final", 8'h11, 8'h77, 8'h33, 8'h88);
        chk("unlock_upd_d", {28'h0, upd}, 32'h8);
        chk("unlock_busy2", {31'h0, busy}, 32'h0);

        // Same destination twice back-to-back
        in_data = 8'h01; sel = 2'b00; in_valid = 1'b1;
        tick();
        in_data = 8'h02;
        tick();
        in_valid = 1'b0;
        chk("b2b_a1", {24'h0, out_a}, 32'h01);
        chk("b2b_upd1", {28'h0, upd}, 32'h1);
        tick();
        chk("b2b_a2", {24'h0, out_a}, 32'h02);
        chk("b2b_upd2", {28'h0, upd}, 32'h1);
        tick();
        chk("b2b_upd_off", {28'h0, upd}, 32'h0);

        // Locks on other destinations do not stall
        lock = 4'b1110;
        in_data = 8'h3C; sel = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("other_lock_ready", {31'h0, in_ready}, 32'h1);
        tick();
        chk_outs("other_lock_out", 8'h3C, 8'h77, 8'h33, 8'h88);
        chk("other_lock_upd", {28'h0, upd}, 32'h1);
        lock = 4'b0000;
        tick();

        // Reset in the middle of a stall
        lock = 4'b0001;
        in_data = 8'h99; sel = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("rstmid_busy_before", {31'h0, busy}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs("rstmid_out", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rstmid_busy", {31'h0, busy}, 32'h0);
        tick();
        rst_n = 1'b1;
        lock = 4'b0000;
        tick();
        chk("rstmid_upd1", {28'h0, upd}, 32'h0);
        tick();
        chk("rstmid_upd2", {28'h0, upd}, 32'h0);
        chk("rstmid_a", {24'h0, out_a}, 32'h00);
        chk("rstmid_ready", {31'h0, in_ready}, 32'h1);

`ifdef DEMUX_REG4_CLEAR_EN
        // Clear drops a stalled entry and resets the registers
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hFF; sel = 2'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk_outs("clr_load", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        lock = 4'b0100;
        in_data = 8'h12; sel = 2'b10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clear = 1'b1;
        #1;
        chk("clr_ready", {31'h0, in_ready}, 32'h0);
        tick();
        clear = 1'b0;
        lock = 4'b0000;
        chk_outs("clr_out", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("clr_busy", {31'h0, busy}, 32'h0);
        tick();
        chk("clr_upd", {28'h0, upd}, 32'h0);
        chk("clr_c", {24'h0, out_c}, 32'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_reg4

// File: doc/demux_reg4.md
Name: demux_reg4

Overview:
- Write-side counterpart of the CPU's 4-to-1 operand selector.
- Accepts one data word plus a 2-bit destination select over a valid/ready handshake.
- Routes the word into one of four holding registers (OutA..OutD), which feed the selector's InA..InD inputs.
- Contains a one-entry pending buffer with per-destination lock stalls, so a write can wait while its target is in use.

Parameters:
- WIDTH, 8, data width of the input word and of each holding register.
- RESET_VAL, 0, value loaded into OutA..OutD on reset.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- InData  input  WIDTH  write data.
- Sel  input  2  destination: 00=A, 01=B, 10=C, 11=D.
- InValid  input  1  write request present.
- InReady  output  1  block can accept a request this cycle.
- Lock  input  4  bit i high = destination i (0=A..3=D) must not be written.
- OutA, OutB, OutC, OutD  output  WIDTH  holding registers.
- UpdA, UpdB, UpdC, UpdD  output  1  one-cycle strobe; high in the first cycle the new value is visible.
- Busy  output  1  pending buffer occupied.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - OutA..OutD = RESET_VAL; Upd* = 0; Busy = 0; pending buffer empty.
  - InReady = 1 after release.
  - Reset mid-operation discards any pending write, with no strobe.
- FSM has two states, EMPTY and FULL. Busy = (state == FULL).
- Accept: handshake when InValid && InReady at a rising edge. PendData and PendSel are captured at that edge.
- Commit condition: state FULL && !Lock[PendSel].
  - On a commit edge: Out[PendSel] <= PendData, Upd[PendSel] = 1 for exactly one cycle, all other Upd* = 0.
- InReady = (state == EMPTY) || commit condition. This is combinational from state and Lock, never from InValid.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL + commit + accept -> FULL with the new entry (back-to-back, 1 write per cycle).
  - FULL + commit, no accept -> EMPTY.
  - FULL + no commit -> FULL, entry held unchanged, InReady = 0.
- Latency: a request accepted at edge N with its destination unlocked is visible on Out* after edge N+1, and its Upd pulses in that same cycle.
- Lock is sampled only for the pending entry's destination. Locks on other destinations never stall.
- Same destination written twice back-to-back: both commits occur. The Upd strobe stays high for 2 consecutive cycles and the register holds the last value.
- Non-selected Out* registers never change on a commit.
- No width conversion; data is passed bit-exact.

Optional Feature:
- Macro: DEMUX_REG4_CLEAR_EN.
- Defined: adds input port Clear (1 bit, synchronous, active-high).
  - On a Clear edge: OutA..OutD <= RESET_VAL and any pending entry is dropped (state -> EMPTY).
  - No Upd strobes are issued for the cleared or dropped entry.
  - InReady = 0 while Clear is high.
  - Clear has priority over both commit and accept.
- Undefined: the Clear port does not exist and behaviour is exactly as above.

Decomposition:
- Shared package holds:
  - state encoding constants ST_EMPTY and ST_FULL;
  - destination constants S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11 (the same ones used by the operand selector);
  - the default data width constant.
- One natural sub-module, dec2to4: a 2-bit to one-hot 4-bit decoder with an enable. It is used to generate the per-destination write enables and Upd strobes from PendSel and the commit condition.

Test Plan:
- Reset then idle: after release, Out* = 00, Upd* = 0, InReady = 1, Busy = 0.
- Single write: InData=8'h5A, Sel=10, InValid for 1 cycle, Lock=0 -> next cycle OutC=5A and UpdC=1 for one cycle; OutA, OutB, OutD stay 00.
- Stream: writes A=11, B=22, C=33, D=44 on 4 consecutive cycles -> InReady stays 1, each Out updates 1 cycle after its accept, Upd strobes walk A->D.
- Lock stall: Lock=0010, write B=77 followed by write D=88 -> B=77 held, Busy=1, InReady=0, and D=88 is not accepted while Lock=0010. Releasing Lock -> OutB=77 with UpdB, then D=88 is accepted and commits to OutD the next cycle.
- Reset mid-stall: Lock=0001, write A=99, assert Rst_n low asynchronously -> OutA=00, Busy=0, no UpdA after release.
- With DEMUX_REG4_CLEAR_EN: load all four registers with FF, then a pending write C=12 under Lock=0100, then Clear=1 -> all Out* = 00, Busy=0, and no UpdC.
